exec_alu_unit: RTL and testbench
================================

// Module: exec_alu_unit
// PURPOSE
//  Execute-stage arithmetic core of the 5-stage MIPS pipeline: ALU control decode, 32-bit ALU,
//  ALU operand-B mux and branch-target adder. Sits between ID/EX and EX/MEM; its outputs
//  are registered and feed the EX/MEM pipeline register (ALU result, zero flag, branch address).
// PARAMETERS
//  WIDTH  32  datapath width (only 32 is required to be supported)
// PORTS
//  clk              in   1   pipeline clock, all state updates on rising edge
//  rst              in   1   asynchronous, active-high reset
//  alu_op           in   2   ALUop from main control (ID/EX EX bits [3:2])
//  alu_src          in   1   0: operand B = reg_data2; 1: operand B = sign_ext_offset
//  incremented_pc   in   32  PC+4 of the instruction in EX
//  reg_data1        in   32  operand A (rs)
//  reg_data2        in   32  rt register value
//  sign_ext_offset  in   32  sign-extended immediate; bits [5:0] are the R-type funct field
//  alu_result       out  32  registered ALU result
//  zero_flag        out  1   registered, 1 when ALU result == 0
//  branch_address   out  32  registered branch target
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high (port rst); clk is the sole clock.
//  - rst=1: alu_result, zero_flag, branch_address forced to 0 immediately, held while rst=1.
//  - Latency 1 cycle: inputs sampled at rising clk edge, outputs valid after that edge; no handshake,
//    a new operation every cycle.
//  - ALU control (combinational, 3-bit code), funct = sign_ext_offset[5:0]:
//    alu_op=00 -> ADD(010); 01 -> SUB(110); 11 -> ADD (reserved, treated as ADD);
//    alu_op=10 -> funct 100000 ADD(010), 100010 SUB(110), 100100 AND(000), 100101 OR(001),
//    100111 NOR(100), 101010 SLT(111); any other funct -> ADD.
//  - Operand B = alu_src ? sign_ext_offset : reg_data2.
//  - ALU: ADD/SUB modulo 2^32, overflow ignored, no exception; AND/OR/NOR bitwise;
//    SLT signed two's-complement compare, result 32'd1 if A<B else 32'd0.
//  - zero_flag computed from the same cycle's ALU result (== 0), registered alongside it.
//  - branch_address = incremented_pc + (sign_ext_offset << 2), modulo 2^32; bits shifted out
//    of [31] discarded; computed every cycle regardless of alu_op.
//  - Reset released mid-stream: first capture is on the first rising edge with rst=0.
// TESTING
//  1. rst=1 asynchronously mid-cycle with nonzero outputs -> all three outputs 0 without a clock edge.
//  2. alu_op=00, alu_src=1, reg_data1=100, sign_ext_offset=32'hFFFFFFFC -> next edge result=96, zero=0.
//  3. alu_op=01, alu_src=0, reg_data1=reg_data2=7, incremented_pc=32'h40, sign_ext_offset=3
//     -> result=0, zero=1, branch_address=32'h4C.
//  4. alu_op=10, funct=101010, A=32'hFFFFFFFF, B=1 -> result=1; funct=100100, A=32'hF0F0,
//     B=32'hFF00 -> 32'hF000; funct=100111, A=0, B=0 -> 32'hFFFFFFFF.
//  5. Wrap: ADD 32'hFFFFFFFF+1 -> result=0, zero=1; incremented_pc=32'hFFFFFFFC, offset=1
//     -> branch_address=0.
//  6. alu_op=10, funct=000000 (unsupported), A=5, B=6 -> result=11; alu_op=11 likewise -> 11.

Source files
------------

// File: rtl/exec_alu_unit.sv
// Execute-stage arithmetic core: ALU control decode, operand-B select,
// 32-bit ALU and branch-target adder. Results are registered and feed EX/MEM.
module exec_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] incremented_pc,
  input  logic [WIDTH-1:0] reg_data1,
  input  logic [WIDTH-1:0] reg_data2,
  input  logic [WIDTH-1:0] sign_ext_offset,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic [WIDTH-1:0] branch_address
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [2:0]       alu_ctrl;
  logic [5:0]       funct;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] alu_value;
  logic [WIDTH-1:0] branch_sum;
  logic             slt_bit;

  assign funct     = sign_ext_offset[5:0];
  assign operand_b = alu_src ? sign_ext_offset : reg_data2;
  assign slt_bit   = ($signed(reg_data1) < $signed(operand_b));
  // Shifted-out upper offset bits are simply dropped; the add wraps mod 2^WIDTH.
  assign branch_sum = incremented_pc + (sign_ext_offset << 2);

  // Decode ALUop/funct into the ALU operation; reserved and unknown codes fall back to ADD.
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctrl = ALU_ADD;
          6'b100010: alu_ctrl = ALU_SUB;
          6'b100100: alu_ctrl = ALU_AND;
          6'b100101: alu_ctrl = ALU_OR;
          6'b100111: alu_ctrl = ALU_NOR;
          6'b101010: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // ALU datapath; arithmetic overflow is ignored.
  always_comb begin
    alu_value = '0;
    case (alu_ctrl)
      ALU_AND: alu_value = reg_data1 & operand_b;
      ALU_OR:  alu_value = reg_data1 | operand_b;
      ALU_NOR: alu_value = ~(reg_data1 | operand_b);
      ALU_SUB: alu_value = reg_data1 - operand_b;
      ALU_SLT: alu_value = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_value = reg_data1 + operand_b;
    endcase
  end

  // Output registers toward EX/MEM; zero flag tracks the same cycle's result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result     <= '0;
      zero_flag      <= 1'b0;
      branch_address <= '0;
    end else begin
      alu_result     <= alu_value;
      zero_flag      <= (alu_value == '0);
      branch_address <= branch_sum;
    end
  end

endmodule

// File: tb/tb_exec_alu_unit.sv
// Testbench for exec_alu_unit: directed vector table, async reset sequences,
// and randomized operations against a behavioural reference model.
module tb_exec_alu_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [31:0] incremented_pc;
  logic [31:0] reg_data1;
  logic [31:0] reg_data2;
  logic [31:0] sign_ext_offset;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] branch_address;

  int n_pass;
  int n_total;

  exec_alu_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_op         (alu_op),
    .alu_src        (alu_src),
    .incremented_pc (incremented_pc),
    .reg_data1      (reg_data1),
    .reg_data2      (reg_data2),
    .sign_ext_offset(sign_ext_offset),
    .alu_result     (alu_result),
    .zero_flag      (zero_flag),
    .branch_address (branch_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        src;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] off;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic [31:0] exp_br;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_total++;
    if (actual === required) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, actual, required);
  endtask

  // Behavioural model: the operation each ALUop/funct selects, in plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic src,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] off);
    logic [31:0] bv;
    bv = src ? off : b;
    if (op == 2'b01) return a - bv;
    if (op != 2'b10) return a + bv;
    case (off[5:0])
      6'h22:   return a - bv;
      6'h24:   return a & bv;
      6'h25:   return a | bv;
      6'h27:   return ~(a | bv);
      6'h2a:   return ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
      default: return a + bv;
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic src, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] off);
    @(negedge clk);
    alu_op = op; alu_src = src; incremented_pc = pc;
    reg_data1 = a; reg_data2 = b; sign_ext_offset = off;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic [1:0] op, input logic src,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] off, input logic [31:0] er, input logic ez,
                         input logic [31:0] eb);
    vec_t v;
    v.name = name; v.op = op; v.src = src; v.pc = pc; v.a = a; v.b = b; v.off = off;
    v.exp_res = er; v.exp_zero = ez; v.exp_br = eb;
    vecs.push_back(v);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    alu_op = 2'b00; alu_src = 1'b0; incremented_pc = '0;
    reg_data1 = '0; reg_data2 = '0; sign_ext_offset = '0;

    //       name          op     src  pc            a             b             off           res           z     br
    add_vec("add_imm",    2'b00, 1'b1, 32'h0,        32'd100,      32'h0,        32'hFFFFFFFC, 32'd96,       1'b0, 32'hFFFFFFF0);
    add_vec("sub_eq",     2'b01, 1'b0, 32'h40,       32'd7,        32'd7,        32'd3,        32'd0,        1'b1, 32'h4C);
    add_vec("slt_neg",    2'b10, 1'b0, 32'h0,        32'hFFFFFFFF, 32'd1,        32'h2A,       32'd1,        1'b0, 32'hA8);
    add_vec("slt_false",  2'b10, 1'b0, 32'h0,        32'd5,        32'hFFFFFFFF, 32'h2A,       32'd0,        1'b1, 32'hA8);
    add_vec("and",        2'b10, 1'b0, 32'h0,        32'hF0F0,     32'hFF00,     32'h24,       32'hF000,     1'b0, 32'h90);
    add_vec("nor",        2'b10, 1'b0, 32'h0,        32'h0,        32'h0,        32'h27,       32'hFFFFFFFF, 1'b0, 32'h9C);
    add_vec("or",         2'b10, 1'b0, 32'h0,        32'hF0,       32'h0F,       32'h25,       32'hFF,       1'b0, 32'h94);
    add_vec("r_sub",      2'b10, 1'b0, 32'h0,        32'd10,       32'd3,        32'h22,       32'd7,        1'b0, 32'h88);
    add_vec("r_add",      2'b10, 1'b0, 32'h0,        32'd1,        32'd2,        32'h20,       32'd3,        1'b0, 32'h80);
    add_vec("r_src_imm",  2'b10, 1'b1, 32'h0,        32'h100,      32'd999,      32'h22,       32'hDE,       1'b0, 32'h88);
    add_vec("add_wrap",   2'b00, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,        1'b1, 32'h0);
    add_vec("br_neg",     2'b00, 1'b0, 32'h1000,     32'h0,        32'h0,        32'hFFFFFFFF, 32'd0,        1'b1, 32'hFFC);
    add_vec("funct_bad",  2'b10, 1'b0, 32'h0,        32'd5,        32'd6,        32'h0,        32'd11,       1'b0, 32'h0);
    add_vec("op11_add",   2'b11, 1'b0, 32'h0,        32'd5,        32'd6,        32'h0,        32'd11,       1'b0, 32'h0);

    // Reset state, including across a clock edge with live inputs.
    #2;
    check("rst_res", alu_result, 32'd0);
    check("rst_zero", {31'd0, zero_flag}, 32'd0);
    check("rst_br", branch_address, 32'd0);
    drive(2'b00, 1'b0, 32'h40, 32'd3, 32'd4, 32'd1);
    check("rst_hold_res", alu_result, 32'd0);
    check("rst_hold_br", branch_address, 32'd0);

    // First capture on the first edge after release.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_res", alu_result, 32'd7);
    check("release_br", branch_address, 32'h44);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].src, vecs[i].pc, vecs[i].a, vecs[i].b, vecs[i].off);
      check({vecs[i].name, "_res"}, alu_result, vecs[i].exp_res);
      check({vecs[i].name, "_zero"}, {31'd0, zero_flag}, {31'd0, vecs[i].exp_zero});
      check({vecs[i].name, "_br"}, branch_address, vecs[i].exp_br);
    end

    // Asynchronous reset mid-cycle with nonzero outputs.
    drive(2'b00, 1'b0, 32'h200, 32'd20, 32'd22, 32'd5);
    check("pre_async_res", alu_result, 32'd42);
    #2;
    rst = 1'b1;
    #1;
    check("async_res", alu_result, 32'd0);
    check("async_zero", {31'd0, zero_flag}, 32'd0);
    check("async_br", branch_address, 32'd0);
    drive(2'b01, 1'b0, 32'h10, 32'd9, 32'd9, 32'd2);
    check("async_hold_res", alu_result, 32'd0);
    check("async_hold_zero", {31'd0, zero_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rerelease_res", alu_result, 32'd0);
    check("rerelease_zero", {31'd0, zero_flag}, 32'd1);
    check("rerelease_br", branch_address, 32'h18);

    // Randomized operations against the reference model.
    for (int k = 0; k < 300; k++) begin
      logic [1:0]  op;
      logic        src;
      logic [31:0] pc, a, b, off, er, eb;
      logic [5:0]  fsel[6];
      fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h24;
      fsel[3] = 6'h25; fsel[4] = 6'h27; fsel[5] = 6'h2A;
      op  = 2'($urandom_range(0, 3));
      src = 1'($urandom_range(0, 1));
      pc  = $urandom;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      off = $urandom;
      if (op == 2'b10 && $urandom_range(0, 4) != 0)
        off[5:0] = fsel[$urandom_range(0, 5)];
      if (src && $urandom_range(0, 3) == 0) a = off;
      er = ref_alu(op, src, a, b, off);
      eb = pc + {off[29:0], 2'b00};
      drive(op, src, pc, a, b, off);
      check($sformatf("rnd%0d_res", k), alu_result, er);
      check($sformatf("rnd%0d_zero", k), {31'd0, zero_flag}, {31'd0, (er == 32'd0)});
      check($sformatf("rnd%0d_br", k), branch_address, eb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
